// File: rtl/booth_seq_mult_if.sv
// rtl/booth_seq_mult_if.sv - addsub connection bundle for the Booth multiplier
interface booth_seq_mult_if #(
  parameter int DW = 8
);
  logic [DW:0] as_dataa;
  logic [DW:0] as_datab;
  logic        as_add_sub;
  logic [DW:0] as_result;

  modport master (
    output as_dataa,
    output as_datab,
    output as_add_sub,
    input  as_result
  );

  modport slave (
    input  as_dataa,
    input  as_datab,
    input  as_add_sub,
    output as_result
  );
endinterface

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential signed radix-2 Booth multiplier, one step per clock
module booth_seq_mult #(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DW-1:0]        multiplicand,
  input  logic [DW-1:0]        multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*DW-1:0]      product,
  booth_seq_mult_if.master     as_bus
);
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [DW:0]   a;
  logic [DW:0]   m;
  logic [DW-1:0] q;
  logic          q_1;
  logic [CW-1:0] count;
  logic [DW:0]   s;

  assign as_bus.as_dataa   = a;
  assign as_bus.as_datab   = m;
  assign as_bus.as_add_sub = !((state == RUN) && q[0] && !q_1);

  // Only pairs 01/10 take the addsub result; 00/11 just shift A.
  always_comb begin
    s = a;
    if (q[0] != q_1) s = as_bus.as_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a     <= '0;
            m     <= {multiplicand[DW-1], multiplicand};
            q     <= multiplier;
            q_1   <= 1'b0;
            count <= CW'(DW);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a     <= {s[DW], s[DW:1]};
          q     <= {s[0], q[DW-1:1]};
          q_1   <= q[0];
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            // Post-shift {A[DW-1:0],Q} collapses to {S, Q[DW-1:1]}.
            product <= {s, q[DW-1:1]};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - self-checking bench for booth_seq_mult with an addsub model
module tb_booth_seq_mult;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] multiplicand;
  logic [DW-1:0] multiplier;
  logic          busy;
  logic          done;
  logic [2*DW-1:0] product;

  int checks = 0;
  int errors = 0;

  booth_seq_mult_if #(.DW(DW)) bus ();

  assign bus.as_result = bus.as_add_sub ? (bus.as_dataa + bus.as_datab)
                                        : (bus.as_dataa - bus.as_datab);

  booth_seq_mult #(.DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .as_bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mult(input logic [7:0] mi, input logic [7:0] qi);
    int pa;
    int pb;
    int p;
    pa = int'($signed(mi));
    pb = int'($signed(qi));
    p  = pa * pb;
    return p[15:0];
  endfunction

  // One full operation with fixed-cycle expectations for busy/done/add_sub/product.
  task automatic run_op(input logic [7:0] mi, input logic [7:0] qi,
                        input logic [15:0] exp, input bit hold, input string tag);
    logic prev;
    logic sub;
    @(negedge clk);
    multiplicand = mi;
    multiplier   = qi;
    start        = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < DW; i++) begin
      sub = qi[i] & ~prev;
      prev = qi[i];
      chk({tag, "_busy_run"}, busy, 1'b1);
      chk({tag, "_done_run"}, done, 1'b0);
      chk({tag, "_add_sub"}, bus.as_add_sub, !sub);
      if (i == 0) chk({tag, "_datab"}, bus.as_datab, {mi[7], mi});
      if (hold) begin
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b1);
    chk({tag, "_product"}, product, exp);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_width"}, done, 1'b0);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_product_hold"}, product, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rm;
    logic [7:0] rq;
    bit         seen;

    vecs[0] = '{8'h03, 8'h05, 16'h000F, "m3q5"};
    vecs[1] = '{8'hFD, 8'h05, 16'hFFF1, "mn3q5"};
    vecs[2] = '{8'h05, 8'hFD, 16'hFFF1, "m5qn3"};
    vecs[3] = '{8'h80, 8'h80, 16'h4000, "mminqmin"};
    vecs[4] = '{8'h80, 8'h7F, 16'hC080, "mminqmax"};
    vecs[5] = '{8'h00, 8'hFF, 16'h0000, "m0qn1"};

    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_product", product, 16'h0000);
    chk("rst_add_sub", bus.as_add_sub, 1'b1);
    chk("rst_dataa", bus.as_dataa, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].m, vecs[i].q, vecs[i].exp, 1'b0, vecs[i].name);

    // start held high throughout, operands scrambled during RUN
    run_op(8'h07, 8'h06, 16'h002A, 1'b1, "hold");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("hold_single_done", seen, 1'b0);
    chk("hold_product", product, 16'h002A);

    // reset during RUN cycle 4
    @(negedge clk);
    multiplicand = 8'h09;
    multiplier   = 8'hF9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_product", product, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 1'b0);
    run_op(8'h02, 8'h02, 16'h0004, 1'b0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      run_op(rm, rq, ref_mult(rm, rq), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
